sram_lsu_ctrl: RTL and testbench

MEM-stage load/store controller between the EX/MEM pipeline register and the off-chip 256Kx16 asynchronous SRAM. Turns each 32-bit RISC-V load or store into one or two registered 16-bit SRAM accesses. Produces sram_stall, which the hazard unit uses to freeze the whole pipeline. Sits directly upstream of the hazard unit.

---
 rtl/sram_lsu_pkg.sv | 27 ++
 rtl/sram_rdata_align.sv | 26 ++
 rtl/sram_lsu_ctrl.sv | 145 ++++++++++++++
 tb/tb_sram_lsu_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_lsu_pkg.sv
// Shared types and constants for the MEM-stage SRAM load/store controller.
package sram_lsu_pkg;

  localparam int SRAM_HALF_W = 16;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    IDLE, ACC_LO, HOLD_LO, ACC_HI, HOLD_HI, DONE
  } lsu_state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

  // Unsupported funct3 encodings fall through to a word access.
  function automatic acc_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/sram_rdata_align.sv
// Load result extraction: picks the half/byte lane from the captured word and extends it.
module sram_rdata_align
  import sram_lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  output logic [31:0] rdata
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half     = addr[1] ? data[31:16] : data[15:0];
    byte_sel = addr[0] ? half[15:8] : half[7:0];
    case (funct3)
      F3_LB:   rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  rdata = {24'h0, byte_sel};
      F3_LH:   rdata = {{16{half[15]}}, half};
      F3_LHU:  rdata = {16'h0, half};
      default: rdata = data;
    endcase
  end

endmodule

// File: rtl/sram_lsu_ctrl.sv
// MEM-stage load/store controller for a 256Kx16 async SRAM; splits 32-bit accesses into 16-bit ones.
// Optional SRAM_MISALIGN_TRAP_EN: misaligned requests skip the SRAM and raise misaligned for one cycle.
module sram_lsu_ctrl
  import sram_lsu_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wren,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       rdata,
  output logic              sram_stall,
  output logic              misaligned,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  localparam int CNT_W = 3;

  lsu_state_e       state, state_n;
  logic [CNT_W-1:0] wait_cnt;
  logic [15:0]      cap_lo;
  acc_size_e        size;
  logic             acc_last, mis_req;
  logic             active_n, acc_n, hi_n;
  logic [ADDR_W-1:0] lo_addr, hi_addr;
  logic [15:0]      lo_wdata;
  logic [31:0]      cap_word, rdata_new;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+1];

  assign size     = f3_size(req_funct3);
  assign acc_last = (wait_cnt == CNT_W'(WAIT_CYCLES - 1));

  // Word accesses ignore addr[1:0]; without the trap this is what aligns them.
  assign lo_addr  = (size == SZ_W) ? {req_addr[ADDR_W:2], 1'b0} : req_addr[ADDR_W:1];
  assign hi_addr  = {req_addr[ADDR_W:2], 1'b1};
  assign lo_wdata = (size == SZ_B) ? {2{req_wdata[7:0]}} : req_wdata[15:0];

`ifdef SRAM_MISALIGN_TRAP_EN
  assign mis_req = ((size == SZ_H) && req_addr[0]) || ((size == SZ_W) && (|req_addr[1:0]));
`else
  assign mis_req = 1'b0;
`endif

  assign sram_stall = ((state == IDLE) && req_valid) ||
                      (state inside {ACC_LO, HOLD_LO, ACC_HI, HOLD_HI});

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = mis_req ? DONE : ACC_LO;
      ACC_LO:  if (acc_last) begin
                 if (req_wren)          state_n = HOLD_LO;
                 else if (size == SZ_W) state_n = ACC_HI;
                 else                   state_n = DONE;
               end
      HOLD_LO: state_n = (size == SZ_W) ? ACC_HI : DONE;
      ACC_HI:  if (acc_last) state_n = req_wren ? HOLD_HI : DONE;
      HOLD_HI: state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strobes are registered, so they are decoded from the state being entered.
  always_comb begin
    active_n = state_n inside {ACC_LO, HOLD_LO, ACC_HI, HOLD_HI};
    acc_n    = state_n inside {ACC_LO, ACC_HI};
    hi_n     = state_n inside {ACC_HI, HOLD_HI};
  end

  // The high half of a word lands on sram_dq_i in the same cycle rdata is loaded.
  always_comb begin
    if (state == ACC_HI)  cap_word = {sram_dq_i, cap_lo};
    else if (req_addr[1]) cap_word = {sram_dq_i, 16'h0};
    else                  cap_word = {16'h0, sram_dq_i};
  end

  sram_rdata_align u_align (
    .data   (cap_word),
    .funct3 (req_funct3),
    .addr   (req_addr[1:0]),
    .rdata  (rdata_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cap_lo     <= '0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
    end else begin
      state      <= state_n;
      sram_ce_n  <= !active_n;
      sram_oe_n  <= !(acc_n && !req_wren);
      sram_we_n  <= !(acc_n && req_wren);
      sram_dq_oe <= active_n && req_wren;
      sram_lb_n  <= !active_n || ((size == SZ_B) && req_addr[0]);
      sram_ub_n  <= !active_n || ((size == SZ_B) && !req_addr[0]);
      if (active_n) begin
        sram_addr <= hi_n ? hi_addr : lo_addr;
        if (req_wren) sram_dq_o <= hi_n ? req_wdata[31:16] : lo_wdata;
      end
      if ((state inside {ACC_LO, ACC_HI}) && !acc_last) wait_cnt <= wait_cnt + CNT_W'(1);
      else                                               wait_cnt <= '0;
      if ((state == ACC_LO) && acc_last && !req_wren) cap_lo <= sram_dq_i;
      if ((state inside {ACC_LO, ACC_HI}) && acc_last && !req_wren && (state_n == DONE))
        rdata <= rdata_new;
    end
  end

`ifdef SRAM_MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= (state == IDLE) && (state_n == DONE);
  end
  assign misaligned = mis_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_sram_lsu_ctrl.sv
// Directed bench for sram_lsu_ctrl with a behavioural async SRAM model.
module tb_sram_lsu_ctrl;
  import sram_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wren;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] rdata;
  logic        sram_stall, misaligned;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_lsu_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wren(req_wren),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rdata(rdata), .sram_stall(sram_stall), .misaligned(misaligned),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  // SRAM model: a write commits when we_n rises while ce_n is still low.
  logic [15:0] mem [0:1023] = '{default: 16'h0};
  logic        prev_we_n = 1'b1;
  logic [9:0]  wa = '0;
  logic [15:0] wd = '0;
  logic        wlb = 1'b1, wub = 1'b1;

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0;

  always @(negedge clk) begin
    if (!prev_we_n && sram_we_n && !sram_ce_n) begin
      if (!wlb) mem[wa][7:0]  <= wd[7:0];
      if (!wub) mem[wa][15:8] <= wd[15:8];
    end
    if (!sram_we_n) begin
      wa  <= sram_addr[9:0];
      wd  <= sram_dq_o;
      wlb <= sram_lb_n;
      wub <= sram_ub_n;
    end
    prev_we_n <= sram_we_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wdat, input bit keep,
                        output int stalls, output bit ce_seen, output logic lbn,
                        output logic ubn, output logic [17:0] ha, output logic [15:0] dq1,
                        output logic mis);
    bit wr_seen = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wren = wr; req_funct3 = f3; req_addr = a; req_wdata = wdat;
    stalls = 0; ce_seen = 0; lbn = 1'b1; ubn = 1'b1; ha = '0; dq1 = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!sram_ce_n && !ce_seen) begin
        ce_seen = 1; lbn = sram_lb_n; ubn = sram_ub_n; ha = sram_addr;
      end
      if (!sram_we_n && !wr_seen) begin
        wr_seen = 1; dq1 = sram_dq_o;
      end
      if (!sram_stall) break;
      stalls++;
    end
    mis = misaligned;
    if (!keep) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    int          stalls;
    logic        ce;
    logic        lbn;
    logic        ubn;
    logic [17:0] ha;
    logic [15:0] dq;
    logic [31:0] rd;
    logic        mis;
  } vec_t;

  vec_t tv[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int          st;
    bit          ce;
    logic        lbn, ubn, mis;
    logic [17:0] ha;
    logic [15:0] dq;

    tv.push_back('{1'b1, F3_LW,  32'h100, 32'hDEADBEEF, 5, 1'b1, 1'b0, 1'b0, 18'h80, 16'hBEEF, 32'h0,        1'b0});
    tv.push_back('{1'b0, F3_LW,  32'h100, 32'h0,        3, 1'b1, 1'b0, 1'b0, 18'h80, 16'h0,    32'hDEADBEEF, 1'b0});
    tv.push_back('{1'b0, F3_LB,  32'h103, 32'h0,        2, 1'b1, 1'b1, 1'b0, 18'h81, 16'h0,    32'hFFFFFFDE, 1'b0});
    tv.push_back('{1'b0, F3_LBU, 32'h103, 32'h0,        2, 1'b1, 1'b1, 1'b0, 18'h81, 16'h0,    32'h000000DE, 1'b0});
    tv.push_back('{1'b0, F3_LH,  32'h100, 32'h0,        2, 1'b1, 1'b0, 1'b0, 18'h80, 16'h0,    32'hFFFFBEEF, 1'b0});
    tv.push_back('{1'b0, F3_LHU, 32'h102, 32'h0,        2, 1'b1, 1'b0, 1'b0, 18'h81, 16'h0,    32'h0000DEAD, 1'b0});
    tv.push_back('{1'b0, F3_LB,  32'h100, 32'h0,        2, 1'b1, 1'b0, 1'b1, 18'h80, 16'h0,    32'hFFFFFFEF, 1'b0});
    tv.push_back('{1'b1, F3_LB,  32'h105, 32'h0000005A, 3, 1'b1, 1'b1, 1'b0, 18'h82, 16'h5A5A, 32'hFFFFFFEF, 1'b0});
    tv.push_back('{1'b0, F3_LHU, 32'h104, 32'h0,        2, 1'b1, 1'b0, 1'b0, 18'h82, 16'h0,    32'h00005A00, 1'b0});
    tv.push_back('{1'b1, F3_LH,  32'h106, 32'h12348001, 3, 1'b1, 1'b0, 1'b0, 18'h83, 16'h8001, 32'h00005A00, 1'b0});
    tv.push_back('{1'b0, F3_LH,  32'h106, 32'h0,        2, 1'b1, 1'b0, 1'b0, 18'h83, 16'h0,    32'hFFFF8001, 1'b0});
    tv.push_back('{1'b0, F3_LW,  32'h104, 32'h0,        3, 1'b1, 1'b0, 1'b0, 18'h82, 16'h0,    32'h80015A00, 1'b0});
    tv.push_back('{1'b0, 3'b011, 32'h100, 32'h0,        3, 1'b1, 1'b0, 1'b0, 18'h80, 16'h0,    32'hDEADBEEF, 1'b0});
    tv.push_back('{1'b0, 3'b110, 32'h104, 32'h0,        3, 1'b1, 1'b0, 1'b0, 18'h82, 16'h0,    32'h80015A00, 1'b0});
`ifdef SRAM_MISALIGN_TRAP_EN
    tv.push_back('{1'b0, F3_LW,  32'h102, 32'h0,        1, 1'b0, 1'b1, 1'b1, 18'h0,  16'h0,    32'h80015A00, 1'b1});
    tv.push_back('{1'b0, F3_LH,  32'h101, 32'h0,        1, 1'b0, 1'b1, 1'b1, 18'h0,  16'h0,    32'h80015A00, 1'b1});
`else
    tv.push_back('{1'b0, F3_LW,  32'h102, 32'h0,        3, 1'b1, 1'b0, 1'b0, 18'h80, 16'h0,    32'hDEADBEEF, 1'b0});
    tv.push_back('{1'b0, F3_LH,  32'h101, 32'h0,        2, 1'b1, 1'b0, 1'b0, 18'h80, 16'h0,    32'hFFFFBEEF, 1'b0});
`endif
    tv.push_back('{1'b0, F3_LBU, 32'h101, 32'h0,        2, 1'b1, 1'b1, 1'b0, 18'h80, 16'h0,    32'h000000BE, 1'b0});
    tv.push_back('{1'b1, F3_LW,  32'h108, 32'h0BADF00D, 5, 1'b1, 1'b0, 1'b0, 18'h84, 16'hF00D, 32'h000000BE, 1'b0});
    tv.push_back('{1'b0, F3_LW,  32'h108, 32'h0,        3, 1'b1, 1'b0, 1'b0, 18'h84, 16'h0,    32'h0BADF00D, 1'b0});

    rst = 1'b1; req_valid = 1'b0; req_wren = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // reset state and idle behaviour
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_strobes", {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
      chk("rst_stall", {31'h0, sram_stall}, 32'h0);
    end
    chk("rst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", {14'h0, sram_addr}, 32'h0);
    chk("rst_dq_o", {16'h0, sram_dq_o}, 32'h0);
    chk("rst_mis", {31'h0, misaligned}, 32'h0);

    foreach (tv[i]) begin
      do_req(tv[i].wr, tv[i].f3, tv[i].a, tv[i].wd, 1'b0, st, ce, lbn, ubn, ha, dq, mis);
      chk($sformatf("v%0d_stalls", i), st, tv[i].stalls);
      chk($sformatf("v%0d_ce", i), {31'h0, ce}, {31'h0, tv[i].ce});
      chk($sformatf("v%0d_rdata", i), rdata, tv[i].rd);
      chk($sformatf("v%0d_mis", i), {31'h0, mis}, {31'h0, tv[i].mis});
      if (tv[i].ce) begin
        chk($sformatf("v%0d_lanes", i), {30'h0, lbn, ubn}, {30'h0, tv[i].lbn, tv[i].ubn});
        chk($sformatf("v%0d_haddr", i), {14'h0, ha}, {14'h0, tv[i].ha});
      end
      if (tv[i].wr) chk($sformatf("v%0d_dq", i), {16'h0, dq}, {16'h0, tv[i].dq});
    end

    chk("mem_80", {16'h0, mem[10'h80]}, 32'hBEEF);
    chk("mem_81", {16'h0, mem[10'h81]}, 32'hDEAD);
    chk("mem_82", {16'h0, mem[10'h82]}, 32'h5A00);
    chk("mem_85", {16'h0, mem[10'h85]}, 32'h0BAD);

    // back-to-back lw then sw: one non-stalled DONE, then stall again in IDLE
    do_req(1'b0, F3_LW, 32'h100, 32'h0, 1'b1, st, ce, lbn, ubn, ha, dq, mis);
    chk("b2b_lw_stalls", st, 3);
    chk("b2b_lw_rdata", rdata, 32'hDEADBEEF);
    chk("b2b_done_stall", {31'h0, sram_stall}, 32'h0);
    do_req(1'b1, F3_LW, 32'h110, 32'h11223344, 1'b0, st, ce, lbn, ubn, ha, dq, mis);
    chk("b2b_sw_stalls", st, 5);
    chk("b2b_sw_haddr", {14'h0, ha}, 32'h88);
    @(negedge clk);
    chk("b2b_mem_89", {16'h0, mem[10'h89]}, 32'h1122);

    // reset during ACC_HI of a word store
    @(posedge clk); #1;
    req_valid = 1'b1; req_wren = 1'b1; req_funct3 = F3_LW; req_addr = 32'h120; req_wdata = 32'hAAAABBBB;
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    chk("rstmid_we_n", {31'h0, sram_we_n}, 32'h0);
    chk("rstmid_addr", {14'h0, sram_addr}, 32'h91);
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_strobes", {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
    chk("rstmid_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
    chk("rstmid_stall", {31'h0, sram_stall}, 32'h0);
    @(negedge clk);
    chk("rstmid_mem_lo", {16'h0, mem[10'h90]}, 32'hBBBB);
    chk("rstmid_mem_hi", {16'h0, mem[10'h91]}, 32'h0);
    do_req(1'b0, F3_LW, 32'h120, 32'h0, 1'b0, st, ce, lbn, ubn, ha, dq, mis);
    chk("rstmid_lw_stalls", st, 3);
    chk("rstmid_lw_rdata", rdata, 32'h0000BBBB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
